// File: rtl/mem_burst_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_burst_pkg : shared widths and FSM state type for the burst controller
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_burst_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 3;
    localparam int c_LEN_W  = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_CAP   = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_burst_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_burst_addr_gen : wrapping word address and remaining-beat counter
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_burst_addr_gen
    import mem_burst_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [LEN_W-1:0]  beats,
    output logic              last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_beats;

    // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_beats <= '0;
        end else if (load) begin
            r_addr  <= load_addr;
            r_beats <= load_len;
        end else if (step) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_beats <= r_beats - LEN_W'(1);
        end
    end

    assign addr  = r_addr;
    assign beats = r_beats;
    assign last  = (r_beats == '0);

endmodule
`default_nettype wire

// File: rtl/mem_burst_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_burst_ctrl : single-port burst read/write controller for a registered word store
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_burst_ctrl
    import mem_burst_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W,
    parameter int LEN_W  = c_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              wr_done,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_add,
    output logic [DATA_W-1:0] mem_wData,
    input  logic [DATA_W-1:0] mem_rData
);

    state_t            r_state;
    state_t            w_next;
    logic              w_load;
    logic              w_step;
    logic [ADDR_W-1:0] w_addr;
    logic [LEN_W-1:0]  w_beats;
    logic              w_last;

    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_valid;
    logic              r_rsp_last;
    logic              r_wr_done;

    mem_burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .load_addr (req_addr),
        .load_len  (req_len),
        .step      (w_step),
        .addr      (w_addr),
        .beats     (w_beats),
        .last      (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_step    = 1'b0;
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_add   = w_addr;
        mem_wData = wr_data;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_load = 1'b1;
                    w_next = req_write ? WR : RD_ISSUE;
                end
            end
            WR: begin
                wr_ready = 1'b1;
                mem_we   = wr_valid;
                if (wr_valid) begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_next = IDLE;
                    end
                end
            end
            RD_ISSUE: begin
                mem_re = 1'b1;
                w_next = RD_CAP;
            end
            RD_CAP: begin
                w_next = RD_RESP;
            end
            RD_RESP: begin
                if (rsp_ready) begin
                    if (w_last) begin
                        w_next = IDLE;
                    end else begin
                        w_step = 1'b1;
                        w_next = RD_ISSUE;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The store returns data one cycle after mem_re, i.e. during RD_CAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            r_wr_done <= (r_state == WR) && wr_valid && w_last;
            if (r_state == RD_CAP) begin
                r_rsp_data  <= mem_rData;
                r_rsp_valid <= 1'b1;
                r_rsp_last  <= w_last;
            end else if ((r_state == RD_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_last  <= 1'b0;
            end
        end
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;
    assign wr_done   = r_wr_done;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_burst_ctrl : directed table, hand sequences and random bursts against a word-array model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_burst_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic          wr_done, busy, mem_we, mem_re;
    logic [AW-1:0] mem_add;
    logic [DW-1:0] mem_wData, mem_rData;

    mem_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .wr_done(wr_done), .busy(busy),
        .mem_we(mem_we), .mem_re(mem_re), .mem_add(mem_add),
        .mem_wData(mem_wData), .mem_rData(mem_rData)
    );

    always #5 clk = ~clk;

    // Registered word store seen by the DUT.
    logic          init_store;
    logic [DW-1:0] store [8];
    always @(posedge clk) begin
        if (init_store) begin
            for (int j = 0; j < 8; j++) store[j] <= '0;
            mem_rData <= '0;
        end else begin
            if (mem_we) store[mem_add] <= mem_wData;
            if (mem_re) mem_rData <= store[mem_add];
        end
    end

    // Transaction-level reference: contents implied by the completed write beats.
    logic [DW-1:0] ref_mem [8];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic             wr;
        logic [2:0]       addr;
        logic [2:0]       len;
        logic [2:0]       stall;
        logic [7:0][31:0] d;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [2:0] a, input logic [2:0] l,
                                input logic [2:0] st, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3);
        vec_t v;
        v = '0;
        v.wr = wr; v.addr = a; v.len = l; v.stall = st;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        return v;
    endfunction

    task automatic do_write(input logic [2:0] a, input logic [2:0] l,
                            input logic [7:0][31:0] d, input bit gaps);
        logic [2:0] ea;
        logic       v;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
        wr_valid  = gaps ? 1'($urandom) : 1'b0;
        rsp_ready = 1'($urandom);
        @(negedge clk);
        chk("wr_req_ready", 32'(req_ready), 32'd1);
        chk("wr_idle_we", 32'(mem_we), 32'd0);
        step();
        req_valid = 1'b0;
        req_addr  = 3'($urandom);
        for (int i = 0; i <= int'(l); ) begin
            v = gaps ? ($urandom_range(3, 0) != 0) : 1'b1;
            wr_valid = v;
            wr_data  = v ? d[i] : $urandom;
            ea = a + 3'(i);
            @(negedge clk);
            chk("wr_busy", 32'(busy), 32'd1);
            chk("wr_ready", 32'(wr_ready), 32'd1);
            chk("wr_req_held", 32'(req_ready), 32'd0);
            chk("wr_we", 32'(mem_we), 32'(v));
            chk("wr_done_early", 32'(wr_done), 32'd0);
            if (v) begin
                chk("wr_addr", 32'(mem_add), 32'(ea));
                chk("wr_data", mem_wData, d[i]);
                ref_mem[ea] = d[i];
                i++;
            end
            step();
        end
        wr_valid = 1'($urandom);
        @(negedge clk);
        chk("wr_done_pulse", 32'(wr_done), 32'd1);
        chk("wr_busy_end", 32'(busy), 32'd0);
        chk("wr_stray_we", 32'(mem_we), 32'd0);
        step();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_done_once", 32'(wr_done), 32'd0);
        step();
    endtask

    task automatic do_read(input logic [2:0] a, input logic [2:0] l, input logic [7:0][31:0] e,
                           input int stall, input bit rnd);
        logic [2:0] ea;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
        wr_valid  = rnd ? 1'($urandom) : 1'b0;
        rsp_ready = rnd ? 1'($urandom) : 1'b1;
        @(negedge clk);
        chk("rd_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i <= int'(l); i++) begin
            ea = a + 3'(i);
            for (int k = 1; k <= 2; k++) begin
                rsp_ready = rnd ? 1'($urandom) : 1'b1;
                wr_valid  = rnd ? 1'($urandom) : 1'b0;
                @(negedge clk);
                chk("rd_valid_early", 32'(rsp_valid), 32'd0);
                chk("rd_re", 32'(mem_re), 32'(k == 1));
                chk("rd_busy", 32'(busy), 32'd1);
                chk("rd_stray_we", 32'(mem_we), 32'd0);
                if (k == 1) chk("rd_addr", 32'(mem_add), 32'(ea));
                step();
            end
            for (int s = 0; s <= stall; s++) begin
                rsp_ready = (s == stall);
                wr_valid  = rnd ? 1'($urandom) : 1'b0;
                @(negedge clk);
                chk("rd_valid", 32'(rsp_valid), 32'd1);
                chk("rd_data", rsp_data, e[i]);
                chk("rd_last", 32'(rsp_last), 32'(i == int'(l)));
                chk("rd_stall_re", 32'(mem_re), 32'd0);
                step();
            end
        end
        rsp_ready = rnd ? 1'($urandom) : 1'b1;
        wr_valid  = 1'b0;
        @(negedge clk);
        chk("rd_busy_end", 32'(busy), 32'd0);
        chk("rd_valid_end", 32'(rsp_valid), 32'd0);
        step();
    endtask

    vec_t             tbl [6];
    logic [7:0][31:0] ex;
    int               hs;
    bit               done;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; init_store = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
        for (int j = 0; j < 8; j++) ref_mem[j] = '0;

        tbl[0] = mk(1'b1, 3'd4, 3'd3, 3'd0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        tbl[1] = mk(1'b0, 3'd4, 3'd3, 3'd0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        tbl[2] = mk(1'b1, 3'd7, 3'd1, 3'd0, 32'h11, 32'h22, 32'h0,  32'h0);
        tbl[3] = mk(1'b0, 3'd7, 3'd1, 3'd0, 32'h11, 32'h22, 32'h0,  32'h0);
        tbl[4] = mk(1'b0, 3'd4, 3'd0, 3'd5, 32'hA0, 32'h0,  32'h0,  32'h0);
        tbl[5] = mk(1'b0, 3'd6, 3'd3, 3'd1, 32'hA2, 32'h11, 32'h22, 32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        step();
        reset = 1'b0; init_store = 1'b0;
        step();

        for (int t = 0; t < 6; t++) begin
            if (tbl[t].wr) do_write(tbl[t].addr, tbl[t].len, tbl[t].d, 1'b0);
            else           do_read(tbl[t].addr, tbl[t].len, tbl[t].d, int'(tbl[t].stall), 1'b0);
        end

        // Reset in the middle of the third beat of a 4-beat write at address 0.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd0; req_len = 3'd3;
        @(negedge clk);
        chk("mr_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 32'hB0 + i;
            @(negedge clk);
            chk("mr_we", 32'(mem_we), 32'd1);
            ref_mem[i] = 32'hB0 + i;
            step();
        end
        wr_valid = 1'b1; wr_data = 32'hB2;
        #2 reset = 1'b1;
        #1;
        chk("mr_async_busy", 32'(busy), 32'd0);
        chk("mr_async_we", 32'(mem_we), 32'd0);
        chk("mr_async_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("mr_wr_done", 32'(wr_done), 32'd0);
        step();
        chk("mr_wr_done_after", 32'(wr_done), 32'd0);
        chk("mr_we_after", 32'(mem_we), 32'd0);
        reset = 1'b0; wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) ex[i] = ref_mem[i];
        do_read(3'd0, 3'd3, ex, 0, 1'b0);

        // Request held high across an active read burst.
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4; req_len = 3'd3;
        @(negedge clk);
        chk("hold_first_accept", 32'(req_ready), 32'd1);
        step();
        hs = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (busy) begin
                chk("hold_req_ready", 32'(req_ready), 32'd0);
                if (rsp_valid) hs++;
            end else begin
                chk("hold_accept", 32'(req_ready), 32'd1);
                chk("hold_beats", 32'(hs), 32'd4);
                done = 1'b1;
            end
            step();
        end
        if (!done) chk("hold_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
            step();
        end
        chk("hold_drain", 32'(done), 32'd1);

        // Random bursts against the reference array.
        for (int n = 0; n < 40; n++) begin
            logic [2:0] a, l;
            a = 3'($urandom);
            l = 3'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                for (int i = 0; i < 8; i++) ex[i] = $urandom;
                do_write(a, l, ex, 1'b1);
            end else begin
                for (int i = 0; i < 8; i++) ex[i] = ref_mem[3'(a + 3'(i))];
                do_read(a, l, ex, $urandom_range(3, 0), 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32, word width.
- ADDR_W, 3, word address width (8 words).
- LEN_W, 3, burst length field width, encoded as beats-1.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  burst request offered.
- req_ready  out  1  request accepted when valid and ready are both high.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  first word address.
- req_len  in  LEN_W  beats-1 (0 gives 1 beat, 7 gives 8 beats).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted when valid and ready are both high.
- wr_data  in  DATA_W  write beat data.
- rsp_valid  out  1  read beat available.
- rsp_ready  in  1  read beat consumed when valid and ready are both high.
- rsp_data  out  DATA_W  read beat data.
- rsp_last  out  1  marks the final read beat.
- wr_done  out  1  one-cycle pulse after the final write beat.
- busy  out  1  high whenever state is not IDLE.
- mem_we, mem_re  out  1  write / read strobes to the word store.
- mem_add  out  ADDR_W  store address.
- mem_wData  out  DATA_W  store write data.
- mem_rData  in  DATA_W  store read data; registered by the store, valid one cycle after mem_re.

Function
REQ-003 The FSM SHALL have the states IDLE, WR, RD_ISSUE, RD_CAP and RD_RESP.
REQ-004 req_ready SHALL be high only in IDLE. On acceptance the block SHALL latch addr=req_addr and beats=req_len, then move to WR if req_write is 1, else to RD_ISSUE.
REQ-005 WR state behaviour:
- wr_ready SHALL be 1.
- mem_we SHALL be the combinational AND of wr_valid and (state==WR).
- mem_add SHALL equal addr; mem_wData SHALL equal wr_data.
- Each accepted beat SHALL increment addr and decrement beats.
REQ-006 After the write beat taken with beats==0, the FSM SHALL go to IDLE and wr_done SHALL be 1 for exactly that next cycle.
REQ-007 Read path, one beat at a time:
- RD_ISSUE: mem_re=1 and mem_add=addr for exactly one cycle, then go to RD_CAP.
- RD_CAP: register mem_rData into rsp_data, then go to RD_RESP.
REQ-008 In RD_RESP, rsp_valid SHALL be 1, and rsp_data and rsp_last (beats==0) SHALL be held stable until rsp_ready.
- On handshake with beats==0, go to IDLE.
- On handshake otherwise, increment addr, decrement beats, and go to RD_ISSUE.
REQ-009 Read latency from request acceptance SHALL be 3 cycles to first rsp_valid; each later beat SHALL be 3 cycles after the previous handshake.
REQ-010 Address arithmetic SHALL be modulo 2^ADDR_W (7+1 wraps to 0); bursts crossing 7 SHALL wrap without error.
REQ-011 mem_we and mem_re SHALL never be high in the same cycle. Both SHALL be 0 outside WR and RD_ISSUE.
REQ-012 wr_valid outside WR SHALL be ignored; rsp_ready outside RD_RESP SHALL be ignored.
REQ-013 A request offered while busy SHALL be held off (req_ready=0), not dropped; it SHALL be accepted in the first IDLE cycle.

Reset
REQ-014 Asserting reset SHALL force IDLE immediately, independent of clk.
REQ-015 All registered outputs and state SHALL reset to 0: rsp_data, rsp_valid, rsp_last, wr_done, addr and beats.
REQ-016 During reset, mem_we and mem_re SHALL be 0 in the same cycle (no store write after reset rises).
REQ-017 Reset mid-burst SHALL abandon the burst with no further beats or responses; operation SHALL resume from IDLE on the first clock edge after deassertion.

Structure
REQ-018 Package mem_burst_pkg SHALL hold the state enum typedef and the DATA_W, ADDR_W and LEN_W defaults.
REQ-019 The address register and beat counter (with wrap and last detection) SHALL be one sub-module, mem_burst_addr_gen. The FSM and datapath SHALL remain in mem_burst_ctrl.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write burst req addr=4, len=3, data 0xA0..0xA3 with wr_valid held high -> mem_we on 4 consecutive cycles at addr 4,5,6,7; wr_done pulses once, the cycle after the 4th beat.
- Read burst addr=4, len=3 after the previous scenario, rsp_ready=1 -> rsp_data 0xA0,0xA1,0xA2,0xA3; rsp_last only on 0xA3; first rsp_valid 3 cycles after acceptance.
- Write addr=7, len=1, data 0x11,0x22, then read addr=7, len=1 -> writes land on 7 then 0; read returns 0x11 then 0x22.
- Read with rsp_ready low for 5 cycles in RD_RESP -> rsp_valid and rsp_data held constant; no mem_re pulses issued while stalled.
- Reset asserted mid-write after 2 of 4 beats -> busy, mem_we and req_ready change within the reset cycle; no wr_done; a new request is accepted 1 cycle after deassertion.
- req_valid held high during an active read burst -> req_ready=0 until IDLE, then accepted; mem_we and mem_re never both high.
